// File: rtl/fb_loader_pkg.sv
// +------------------------------------------------------------------+
// | fb_loader_pkg: state encoding and defaults for spi_fb_loader      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package fb_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DATA   = 2'd1;
  localparam state_t ST_CSUM   = 2'd2;
  localparam state_t ST_COMMIT = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// +------------------------------------------------------------------+
// | sync_edge: 2-FF synchronizer with rising-edge pulse output        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic d1;
  logic d2;
  logic d3;

  always_ff @(posedge clk) begin
    if (rst) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
      d3 <= 1'b0;
    end else begin
      d1 <= async_in;
      d2 <= d1;
      d3 <= d2;
    end
  end

  assign rise = d2 & ~d3;

endmodule

`default_nettype wire

// File: rtl/spi_fb_loader.sv
// +------------------------------------------------------------------+
// | spi_fb_loader: frames SPI bytes into one framebuffer write pass   |
// | Optional checksum byte enabled by FB_LOADER_CSUM_EN.  Rev 1.0     |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module spi_fb_loader
  import fb_loader_pkg::*;
#(
  parameter int         FRAME_BYTES = 8000,
  parameter int         ADDR_W      = 13,
  parameter logic [7:0] SOF         = SOF_DEFAULT,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_dr,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic [7:0]        fb_wdata,
  output logic              fb_switch,
  output logic              busy,
  output logic              err,
  output logic [7:0]        frame_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic              rise;
  logic              ev;
  logic [7:0]        rx_byte;
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [TMO_W-1:0]  tmo;
  logic              last_byte;
  logic              tmo_hit;
`ifdef FB_LOADER_CSUM_EN
  logic [7:0]        csum;
`endif

  sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (rx_dr),
    .rise     (rise)
  );

  // rx_data is still stable here because rx_dr is high for the whole edge window
  always_ff @(posedge clk) begin
    if (rst) begin
      ev      <= 1'b0;
      rx_byte <= 8'd0;
    end else begin
      ev <= rise;
      if (rise) rx_byte <= rx_data;
    end
  end

  assign last_byte = (addr == ADDR_W'(FRAME_BYTES - 1));
  assign tmo_hit   = (tmo == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      tmo       <= '0;
      fb_we     <= 1'b0;
      fb_waddr  <= '0;
      fb_wdata  <= 8'd0;
      fb_switch <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      frame_cnt <= 8'd0;
`ifdef FB_LOADER_CSUM_EN
      csum      <= 8'd0;
`endif
    end else begin
      fb_we     <= 1'b0;
      fb_switch <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ev && rx_byte == SOF) begin
            state <= ST_DATA;
            addr  <= '0;
            tmo   <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
`ifdef FB_LOADER_CSUM_EN
            csum  <= 8'd0;
`endif
          end
        end

        ST_DATA: begin
          if (ev) begin
            fb_we    <= 1'b1;
            fb_waddr <= addr;
            fb_wdata <= rx_byte;
            tmo      <= '0;
`ifdef FB_LOADER_CSUM_EN
            csum     <= csum ^ rx_byte;
            if (last_byte) state <= ST_CSUM;
`else
            if (last_byte) state <= ST_COMMIT;
`endif
            else addr <= addr + 1'b1;
          end else if (tmo_hit) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

`ifdef FB_LOADER_CSUM_EN
        ST_CSUM: begin
          if (ev) begin
            tmo <= '0;
            if (rx_byte == csum) begin
              state <= ST_COMMIT;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else if (tmo_hit) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
`endif

        ST_COMMIT: begin
          fb_switch <= 1'b1;
          frame_cnt <= frame_cnt + 8'd1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
